// File: rtl/cpu_pkg.sv
// Shared CPU definitions: micro-op codes, data cache size and LSU FSM states.
// Used by the decoder, the data cache and the load/store unit.
package cpu_pkg;

  localparam logic [4:0] STR_UOP  = 5'b01001;
  localparam logic [4:0] LDR_UOP  = 5'b01010;
  localparam int unsigned DC_WORDS = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, word-addressed data cache access,
// out-of-range LDR/STR answered with a fault and no cache traffic.
module load_store_unit #(
  parameter logic [4:0]  STR_UOP  = cpu_pkg::STR_UOP,
  parameter logic [4:0]  LDR_UOP  = cpu_pkg::LDR_UOP,
  parameter int unsigned DC_WORDS = cpu_pkg::DC_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_uop,
  input  logic [31:0] in_base,
  input  logic [31:0] in_offset,
  input  logic [31:0] in_store_data,
  input  logic [3:0]  in_rd,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_data_in,
  output logic [4:0]  dc_uop,
  input  logic [31:0] dc_data_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        wb_fault
);
  import cpu_pkg::*;

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  logic        is_ld_q;
  logic [31:0] eff_addr;
  logic        is_mem;
  logic        in_range;
  logic        accept;

  assign eff_addr = in_base + in_offset;
  assign is_mem   = (in_uop == STR_UOP) || (in_uop == LDR_UOP);
  assign in_range = eff_addr < DC_WORDS;
  assign in_ready = (state_q == IDLE);
  assign wb_valid = (state_q == RESP);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (is_mem && in_range) ? ACCESS : RESP;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_ld_q    <= 1'b0;
      dc_uop     <= '0;
      dc_addr    <= '0;
      dc_data_in <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_we      <= 1'b0;
      wb_fault   <= 1'b0;
    end else begin
      state_q    <= state_d;
      // cache request lives only in the ACCESS cycle
      dc_uop     <= '0;
      dc_addr    <= '0;
      dc_data_in <= '0;
      if (accept) begin
        is_ld_q  <= (in_uop == LDR_UOP);
        wb_rd    <= in_rd;
        wb_data  <= '0;
        wb_we    <= 1'b0;
        wb_fault <= is_mem && !in_range;
        if (is_mem && in_range) begin
          dc_uop     <= in_uop;
          dc_addr    <= eff_addr;
          dc_data_in <= in_store_data;
        end
      end
      if (state_q == CAPTURE) begin
        wb_data <= is_ld_q ? dc_data_out : '0;
        wb_we   <= is_ld_q;
      end
    end
  end

endmodule
